// File: rtl/aes_round_ctrl_if.sv
// Handshake bundle between the AES wrapper/key schedule/datapath and the round sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface aes_round_ctrl_if #(
  parameter int RCW = 4
);
  logic           start;
  logic           abort;
  logic           rk_req;
  logic [RCW-1:0] rk_idx;
  logic           rk_vld;
  logic           dp_load;
  logic           dp_round_en;
  logic           dp_skip_mix;
  logic [RCW-1:0] round;
  logic           busy;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output start, abort, rk_vld, out_ready,
    input  rk_req, rk_idx, dp_load, dp_round_en, dp_skip_mix, round, busy, out_valid
  );

  modport slave (
    input  start, abort, rk_vld, out_ready,
    output rk_req, rk_idx, dp_load, dp_round_en, dp_skip_mix, round, busy, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: initial AddRoundKey, NUM_ROUNDS rounds
// (last without MixColumns), round-key fetch over req/vld, ciphertext over valid/ready.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RCW        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_round_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RND, OUT} state_t;

  state_t         state_q, state_d;
  logic [RCW-1:0] round_q, round_d;
  logic [RCW-1:0] idx_q, idx_d;
  logic           last_round;

  assign last_round = (round_q == RCW'(NUM_ROUNDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath strobes are Mealy (state AND rk_vld) so each key handshake fires exactly once.
  always_comb begin
    state_d         = state_q;
    round_d         = round_q;
    idx_d           = idx_q;
    bus.dp_load     = 1'b0;
    bus.dp_round_en = 1'b0;
    bus.dp_skip_mix = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      round_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = LOAD;
            round_d = '0;
            idx_d   = '0;
          end
        end
        LOAD: begin
          if (bus.rk_vld) begin
            bus.dp_load = 1'b1;
            state_d     = RND;
            round_d     = RCW'(1);
            idx_d       = RCW'(1);
          end
        end
        RND: begin
          if (bus.rk_vld) begin
            bus.dp_round_en = 1'b1;
            if (last_round) begin
              bus.dp_skip_mix = 1'b1;
              state_d         = OUT;
            end else begin
              round_d = round_q + RCW'(1);
              idx_d   = idx_q + RCW'(1);
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            round_d = '0;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          round_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign bus.rk_req    = (state_q == LOAD) || (state_q == RND);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.rk_idx    = idx_q;
  assign bus.round     = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: key-handshake scoreboard plus latency, stall,
// backpressure, abort, async-reset and 14-round checks.
module tb_aes_round_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if #(.RCW(4)) b10 ();
  aes_round_ctrl_if #(.RCW(4)) b14 ();

  aes_round_ctrl #(.NUM_ROUNDS(10), .RCW(4)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
  aes_round_ctrl #(.NUM_ROUNDS(14), .RCW(4)) dut14 (.clk(clk), .rst_n(rst_n), .bus(b14.slave));

  typedef struct packed {
    logic       ld;
    logic       re;
    logic       sk;
    logic [3:0] idx;
    logic [3:0] rnd;
  } hs_t;

  hs_t q10[$];
  hs_t q14[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  t0    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic hs_t mk(input int k, input int nr);
    hs_t h;
    h.ld  = (k == 0);
    h.re  = (k != 0);
    h.sk  = (k == nr);
    h.idx = 4'(k);
    h.rnd = 4'(k);
    return h;
  endfunction

  task automatic push_enc(input int w, input int nr, input int n);
    for (int k = 0; k < n; k++) begin
      if (w == 10) q10.push_back(mk(k, nr));
      else         q14.push_back(mk(k, nr));
    end
  endtask

  // Every handshake cycle must match the next expected key fetch; every other cycle must be pulse-free.
  task automatic mon(input int w, input logic rq, input logic vld, input logic ab,
                     input logic ld, input logic re, input logic sk,
                     input logic [3:0] idx, input logic [3:0] rnd);
    hs_t got;
    hs_t exp;
    got = {ld, re, sk, idx, rnd};
    if (rq && vld && !ab && rst_n) begin
      chk($sformatf("sb%0d_avail", w), 32'((w == 10) ? (q10.size() != 0) : (q14.size() != 0)), 32'd1);
      if ((w == 10) ? (q10.size() != 0) : (q14.size() != 0)) begin
        exp = (w == 10) ? q10.pop_front() : q14.pop_front();
        chk($sformatf("hs%0d_idx%0d", w, exp.idx), 32'(got), 32'(exp));
      end
    end else begin
      chk($sformatf("nopulse%0d", w), 32'({ld, re}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(10, b10.rk_req, b10.rk_vld, b10.abort, b10.dp_load, b10.dp_round_en, b10.dp_skip_mix,
        b10.rk_idx, b10.round);
    mon(14, b14.rk_req, b14.rk_vld, b14.abort, b14.dp_load, b14.dp_round_en, b14.dp_skip_mix,
        b14.rk_idx, b14.round);
  end

  function automatic logic [13:0] outs(input int w);
    if (w == 10)
      return {b10.busy, b10.out_valid, b10.rk_req, b10.dp_load, b10.dp_round_en, b10.dp_skip_mix,
              b10.rk_idx, b10.round};
    return {b14.busy, b14.out_valid, b14.rk_req, b14.dp_load, b14.dp_round_en, b14.dp_skip_mix,
            b14.rk_idx, b14.round};
  endfunction

  function automatic logic ov(input int w);
    return (w == 10) ? b10.out_valid : b14.out_valid;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 10) b10.start = v;
    else         b14.start = v;
  endtask

  task automatic chk_idle(input string tag, input int w);
    chk(tag, 32'(outs(w)), 32'd0);
  endtask

  task automatic wait_valid(input int w);
    for (int i = 0; i < 100 && !ov(w); i++) tick();
    chk($sformatf("out_valid%0d_seen", w), 32'(ov(w)), 32'd1);
  endtask

  task automatic run_plain(input string tag, input int w, input int nr);
    push_enc(w, nr, nr + 1);
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    t0 = cyc;
    wait_valid(w);
    chk({tag, "_latency"}, 32'(cyc - t0 + 1), 32'(nr + 2));
    tick();
    chk_idle({tag, "_idle_after"}, w);
    chk({tag, "_sb_drained"}, 32'((w == 10) ? q10.size() : q14.size()), 32'd0);
  endtask

  initial begin
    b10.start = 0; b10.abort = 0; b10.rk_vld = 1; b10.out_ready = 1;
    b14.start = 0; b14.abort = 0; b14.rk_vld = 1; b14.out_ready = 1;

    tick();
    tick();
    chk_idle("reset10", 10);
    chk_idle("reset14", 14);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset", 10);

    run_plain("basic", 10, 10);

    // Key stalls: 3 cycles in LOAD, 2 cycles in round 5.
    push_enc(10, 10, 11);
    b10.rk_vld = 0;
    b10.start  = 1;
    tick();
    b10.start = 0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      chk("stall_load_req", 32'({b10.rk_req, b10.rk_idx}), 32'({1'b1, 4'd0}));
      tick();
    end
    b10.rk_vld = 1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("stall_round5", 32'(b10.round), 32'd5);
    b10.rk_vld = 0;
    for (int i = 0; i < 2; i++) begin
      chk("stall_r5_req", 32'({b10.rk_req, b10.rk_idx}), 32'({1'b1, 4'd5}));
      tick();
    end
    b10.rk_vld = 1;
    wait_valid(10);
    chk("stall_latency", 32'(cyc - t0 + 1), 32'd17);
    tick();
    chk_idle("stall_idle_after", 10);

    // Output backpressure with start pulses arriving during OUT.
    push_enc(10, 10, 11);
    b10.out_ready = 0;
    b10.start     = 1;
    tick();
    b10.start = 0;
    t0 = cyc;
    wait_valid(10);
    chk("bp_latency", 32'(cyc - t0 + 1), 32'd12);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", 32'({b10.busy, b10.out_valid, b10.rk_req}), 32'b110);
      b10.start = (i % 2 == 0);
      tick();
    end
    b10.out_ready = 1;
    b10.start     = 1;
    tick();
    b10.start = 0;
    chk_idle("bp_idle", 10);
    tick();
    chk_idle("bp_no_queued_start", 10);

    // Abort in round 6 with rk_vld high.
    push_enc(10, 10, 6);
    b10.start = 1;
    tick();
    b10.start = 0;
    for (int i = 0; i < 50 && b10.round != 4'd6; i++) tick();
    chk("abort_at_round6", 32'(b10.round), 32'd6);
    b10.abort = 1;
    tick();
    b10.abort = 0;
    chk_idle("abort_idle", 10);
    chk("abort_sb_drained", 32'(q10.size()), 32'd0);
    run_plain("after_abort", 10, 10);

    // Asynchronous reset between edges in round 3.
    push_enc(10, 10, 3);
    b10.start = 1;
    tick();
    b10.start = 0;
    for (int i = 0; i < 50 && b10.round != 4'd3; i++) tick();
    chk("rst_at_round3", 32'(b10.round), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst_immediate", 10);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("rst_release_idle", 10);
    chk("rst_sb_drained", 32'(q10.size()), 32'd0);
    run_plain("after_rst", 10, 10);

    run_plain("nr14", 14, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
